alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  3  operation code, latched with start.
REQ-006 a  input  16  operand A, latched with start.
REQ-007 b  input  16  operand B, latched with start; b[3:0] is the shift amount for shifts.
REQ-008 busy  output  1  high while state is EXEC or DONE.
REQ-009 done  output  1  one-cycle pulse; result/carry valid in that cycle.
REQ-010 result  output  16  registered result; drives the downstream zero-detect stage directly.
REQ-011 carry  output  1  registered carry/status bit.

Function
REQ-012 Op codes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (low 16 bits).
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; reset state IDLE.
REQ-014 IDLE with start=1 SHALL latch op/a/b; ADD/SUB/AND/OR/XOR, and SHL/SHR with b[3:0]=0, go directly to DONE; other shifts and MUL go to EXEC.
REQ-015 start SHALL be ignored in EXEC and DONE; no queuing.
REQ-016 Operand input changes after the start cycle SHALL NOT affect the operation.
REQ-017 Latency (start sampled in cycle 0, done high in cycle N): single-cycle ops N=1; shift by n (1..15) N=n+1; MUL N=17.
REQ-018 SHL/SHR SHALL shift one bit per EXEC cycle; iteration count comes from latched b[3:0]; b[15:4] ignored.
REQ-019 MUL SHALL be shift-add, exactly 16 EXEC iterations regardless of operand values (no early exit).
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE; a start in the following IDLE cycle is accepted (back-to-back issue period = N+1 cycles).
REQ-021 result and carry SHALL update only on the transition into DONE and hold until the next transition into DONE.
REQ-022 carry: ADD = carry-out of bit 15; SUB = 1 iff a<b unsigned (borrow); logic ops = 0; SHL/SHR = last bit shifted out (0 if n=0); MUL = 1 iff upper 16 bits of 32-bit product nonzero.
REQ-023 Arithmetic SHALL be unsigned modulo 2^16; ADD/SUB wrap silently.
REQ-024 done SHALL be asserted exactly when state is DONE.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, carry=0, and clear latched operands and the iteration counter.
REQ-026 Reset during EXEC or DONE SHALL abort the operation with no done pulse after release.
REQ-027 First start is accepted on the first rising edge with rst_n high.

Structure
REQ-028 Shared package alu_pkg SHALL hold WIDTH, the op-code constants and the FSM state encoding.
REQ-029 The iterative shift-add multiplier SHALL be a sub-module alu_mc_mul (load, step, product, hi_nonzero); the FSM and iteration counter stay in alu_mc.
REQ-030 result SHALL be a flop output with no combinational path from a, b or op.

Verification
REQ-031 ADD a=16'hFFFF b=16'h0001 -> done in cycle 1, result=16'h0000, carry=1; downstream zero flag=1.
REQ-032 SUB a=16'h0003 b=16'h0005 -> cycle 1, result=16'hFFFE, carry=1.
REQ-033 SHL a=16'h8001 b=16'h0004 -> done in cycle 5, result=16'h0010, carry=0; SHR a=16'h0001 b=0 -> cycle 1, result=16'h0001, carry=0.
REQ-034 MUL a=16'h0100 b=16'h0100 -> done in cycle 17, result=16'h0000, carry=1; MUL a=300 b=200 -> result=16'hEA60, carry=0.
REQ-035 MUL started, start pulsed with ADD in cycle 5, then rst_n low in cycle 10 -> ADD ignored, all outputs 0 immediately, no done pulse after release.
REQ-036 Back-to-back ADD ops with start held high -> done pulses in cycles 1, 3, 5; busy low in cycles 2, 4.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared width, op-code constants, FSM encoding and the
//               single-cycle ALU helper for the multi-cycle ALU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry, result}; shifts here are only the zero-amount case.
    function automatic logic [WIDTH:0] alu_single(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_ADD:         r = {1'b0, a} + {1'b0, b};
            OP_SUB:         r = {1'b0, a} - {1'b0, b};
            OP_AND:         r = {1'b0, a & b};
            OP_OR:          r = {1'b0, a | b};
            OP_XOR:         r = {1'b0, a ^ b};
            OP_SHL, OP_SHR: r = {1'b0, a};
            default:        r = '0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mc_mul.sv
// ============================================================================
// Module      : alu_mc_mul
// Description : Iterative shift-add multiplier, one partial product per step.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mc_mul
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         hi_nonzero
);

    logic [W-1:0]   r_mcand;
    logic [2*W-1:0] r_prod;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_next;

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign w_sum  = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_next = {w_sum, r_prod[W-1:1]};

    // Outputs reflect the value produced by the step taken this cycle.
    assign product    = w_next[W-1:0];
    assign hi_nonzero = |w_next[2*W-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_prod  <= '0;
        end else if (load) begin
            r_mcand <= a;
            r_prod  <= {{W{1'b0}}, b};
        end else if (step) begin
            r_prod  <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle 16-bit ALU: single-cycle logic/arith, iterative
//               shifts (one bit per cycle) and a 16-step shift-add multiply.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;

    logic             w_is_shift_in;
    logic             w_single;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_acc;
    logic             w_shift_out;
    logic             w_mul_load;
    logic             w_mul_step;
    logic [WIDTH-1:0] w_mul_prod;
    logic             w_mul_hi;
    logic [WIDTH:0]   w_single_res;

    assign w_is_shift_in = (op == OP_SHL) || (op == OP_SHR);
    assign w_single      = (op <= OP_XOR) || (w_is_shift_in && (b[3:0] == 4'd0));
    assign w_last        = (r_cnt == 5'd1);
    assign w_single_res  = alu_single(op, a, b);
    assign w_mul_load    = (r_state == ST_IDLE) && start && (op == OP_MUL);
    assign w_mul_step    = (r_state == ST_EXEC) && (r_op == OP_MUL);

    always_comb begin
        w_shift_acc = r_acc;
        w_shift_out = 1'b0;
        if (r_op == OP_SHL) begin
            {w_shift_out, w_shift_acc} = {r_acc, 1'b0};
        end else begin
            {w_shift_acc, w_shift_out} = {1'b0, r_acc};
        end
    end

    alu_mc_mul #(
        .W(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_mul_load),
        .step      (w_mul_step),
        .a         (a),
        .b         (b),
        .product   (w_mul_prod),
        .hi_nonzero(w_mul_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = w_single ? ST_DONE : ST_EXEC;
            ST_EXEC: if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch, iteration counter and the result/carry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_acc <= a;
                        r_cnt <= (op == OP_MUL) ? 5'd16 : {1'b0, b[3:0]};
                        if (w_single) begin
                            {r_carry, r_result} <= w_single_res;
                        end
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_op == OP_MUL) begin
                        if (w_last) begin
                            r_result <= w_mul_prod;
                            r_carry  <= w_mul_hi;
                        end
                    end else begin
                        r_acc <= w_shift_acc;
                        if (w_last) begin
                            r_result <= w_shift_acc;
                            r_carry  <= w_shift_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign carry  = r_carry;

endmodule

`default_nettype wire
